fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It captures `{pc, insn}` pairs from fetch through a valid/ready handshake and presents them in order to decode. It decouples decode stalls from the PC register: fetch's `stall_i` is driven from `!in_ready_o`. A single `flush_i` squashes everything in flight on a redirect (taken branch or jump).

---
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: in-order {pc, insn} circular buffer with flush.
// Latency: 1 cycle from an accepted push to out_valid_o; no bypass path.
// Backpressure: in_ready_o = count != DEPTH (state only; a same-cycle pop does not free a slot).
//
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   flush_i             : squash stored entries and any same-cycle push/pop
//   in_valid_i/in_ready_o, in_pc_i, in_insn_i     : fetch side handshake and payload
//   out_valid_o/out_ready_i, out_pc_o, out_insn_o : decode side handshake and head payload
//   count_o             : number of occupied entries
module fetch_queue #(
   parameter int                AWIDTH   = 32,
   parameter int                DWIDTH   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   input  logic [AWIDTH-1:0]          in_pc_i,
   input  logic [DWIDTH-1:0]          in_insn_i,
   output logic                       in_ready_o,
   output logic                       out_valid_o,
   output logic [AWIDTH-1:0]          out_pc_o,
   output logic [DWIDTH-1:0]          out_insn_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AWIDTH-1:0] pc_mem   [DEPTH];
   logic [DWIDTH-1:0] insn_mem [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // Ready depends on registered count only, keeping decode stalls off the fetch PC path.
   assign in_ready_o  = (count != FULL);
   assign out_valid_o = (count != '0);

   assign push = in_valid_i & in_ready_o  & ~flush_i;
   assign pop  = out_valid_o & out_ready_i & ~flush_i;

   // DEPTH is a power of two, so pointers wrap naturally; count separates full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale contents are never visible because count gates the head mux.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= in_pc_i;
         insn_mem[wr_ptr] <= in_insn_i;
      end
   end

   assign out_pc_o   = out_valid_o ? pc_mem[rd_ptr]   : '0;
   assign out_insn_o = out_valid_o ? insn_mem[rd_ptr] : NOP_INSN;
   assign count_o    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan sequences plus randomized traffic,
// all checked every cycle against a queue-based reference model.
// Ports: none (top-level bench).
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_insn = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   logic        out_ready = 1'b0;
   logic [2:0]  count;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   logic [63:0] mq[$];   // reference model: {pc, insn} in arrival order

   fetch_queue #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_pc_i     (in_pc),
      .in_insn_i   (in_insn),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_pc_o    (out_pc),
      .out_insn_o  (out_insn),
      .out_ready_i (out_ready),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transfer happens only when the rule allows it at the edge.
   always @(posedge clk or posedge rst) begin
      bit pu;
      bit po;
      if (rst) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         pu = in_valid && (mq.size() < DEPTH);
         po = out_ready && (mq.size() > 0);
         if (po) void'(mq.pop_front());
         if (pu) mq.push_back({in_pc, in_insn});
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
         check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
         check("count",     64'(count),     64'(mq.size()));
         if (mq.size() > 0) begin
            check("out_pc",   64'(out_pc),   64'(mq[0][63:32]));
            check("out_insn", 64'(out_insn), 64'(mq[0][31:0]));
         end else begin
            check("out_pc_empty",   64'(out_pc),   64'h0);
            check("out_insn_empty", 64'(out_insn), 64'(NOP));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_insn   = insn;
      out_ready = rdy;
      flush     = fl;
   endtask

   initial begin
      // Reset asserted between edges: outputs must be at their reset values immediately.
      #1;
      check("rst_in_ready",  64'(in_ready),  64'h1);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_pc",    64'(out_pc),    64'h0);
      check("rst_out_insn",  64'(out_insn),  64'h13);
      check("rst_count",     64'(count),     64'h0);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Streaming: each entry visible one cycle after its push, count never above 1.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
         tick();
         check("stream_valid", 64'(out_valid), 64'h1);
         check("stream_pc",    64'(out_pc),    64'(4 * i));
         check("stream_insn",  64'(out_insn),  64'hA0 + 64'(i));
         check("stream_count", 64'(count),     64'h1);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("stream_drained", 64'(count), 64'h0);

      // Fill: five pushes with decode stalled; only four are captured.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0);
         check("fill_ready", 64'(in_ready), 64'(i < 4));
         tick();
      end
      check("fill_count", 64'(count),    64'h4);
      check("fill_ready_low", 64'(in_ready), 64'h0);
      check("fill_head", 64'(out_pc),    64'h100);

      // Pop two, then refill with 0x110 and 0x114.
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();
      check("pop2_count", 64'(count),  64'h2);
      check("pop2_head",  64'(out_pc), 64'h108);
      drive(1'b1, 32'h110, 32'hC0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h114, 32'hC1, 1'b0, 1'b0);
      tick();
      check("refill_count", 64'(count), 64'h4);

      // Full with a same-cycle pop: pop happens, push refused.
      drive(1'b1, 32'h118, 32'hC2, 1'b1, 1'b0);
      tick();
      check("fullpop_count", 64'(count),    64'h3);
      check("fullpop_ready", 64'(in_ready), 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("drain_0", 64'(out_pc), 64'h10C);
      tick();
      check("drain_1", 64'(out_pc), 64'h110);
      tick();
      check("drain_2", 64'(out_pc), 64'h114);
      tick();
      check("drain_empty", 64'(out_valid), 64'h0);

      // Flush with push and pop active together.
      drive(1'b1, 32'h180, 32'hD0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h184, 32'hD1, 1'b0, 1'b0);
      tick();
      check("preflush_count", 64'(count), 64'h2);
      drive(1'b1, 32'h188, 32'hD2, 1'b1, 1'b1);
      tick();
      check("flush_count", 64'(count),     64'h0);
      check("flush_valid", 64'(out_valid), 64'h0);
      drive(1'b1, 32'h200, 32'hD3, 1'b0, 1'b0);
      tick();
      check("postflush_pc", 64'(out_pc), 64'h200);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();

      // Mid-stream reset with three entries held.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 32'hE0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("prerst_count", 64'(count), 64'h3);
      #2 rst = 1'b1;
      #1;
      check("midrst_count", 64'(count),     64'h0);
      check("midrst_valid", 64'(out_valid), 64'h0);
      check("midrst_ready", 64'(in_ready),  64'h1);
      check("midrst_insn",  64'(out_insn),  64'h13);
      rst = 1'b0;
      drive(1'b1, 32'h0, 32'h55, 1'b0, 1'b0);
      tick();
      check("postrst_valid", 64'(out_valid), 64'h1);
      check("postrst_pc",    64'(out_pc),    64'h0);
      check("postrst_insn",  64'(out_insn),  64'h55);

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom, $urandom,
               $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end

      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
